// File: rtl/mul8x8_pkg.sv
// ============================================================================
// mul8x8_pkg : shared state encoding and widths for the 8x8 sequential multiplier
// Revision   : 1.0
// ============================================================================
`default_nettype none

package mul8x8_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = 3'd7;

endpackage

`default_nettype wire

// File: rtl/mul8x8_seq_adder16.sv
// ============================================================================
// adder16 : 16-bit combinational adder, result modulo 2^16
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder16 (
  output logic [15:0] out,
  input  logic [15:0] in1,
  input  logic [15:0] in2
);

  assign out = in1 + in2;

endmodule

`default_nettype wire

// File: rtl/mul8x8_seq.sv
// ============================================================================
// mul8x8_seq : sequential 8x8 unsigned shift-and-add multiplier, start/done handshake
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mul8x8_seq
  import mul8x8_pkg::*;
#(
  parameter int unsigned EARLY_EXIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t              state_q;
  logic [PROD_W-1:0]   mcand_q;
  logic [OP_W-1:0]     mplier_q;
  logic [PROD_W-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q;
  logic [PROD_W-1:0]   product_q;

  logic [PROD_W-1:0]   addend_d;
  logic [PROD_W-1:0]   acc_d;
  logic                finish_d;

  assign addend_d = mplier_q[0] ? mcand_q : '0;

  adder16 u_adder16 (
    .out (acc_d),
    .in1 (acc_q),
    .in2 (addend_d)
  );

  // Early exit fires once no set multiplier bits remain after this step.
  assign finish_d = (cnt_q == LAST_CNT) ||
                    ((EARLY_EXIT != 0) && (mplier_q[OP_W-1:1] == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{(PROD_W-OP_W){1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 3'd1;
          if (finish_d) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_mul8x8_seq.sv
// ============================================================================
// tb_mul8x8_seq : scoreboard bench for both EARLY_EXIT settings of mul8x8_seq
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_mul8x8_seq;

  typedef struct {
    logic [15:0] prod;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
  logic        ready0, busy0, done0, ready1, busy1, done1;
  logic [15:0] product0, product1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  mul8x8_seq #(.EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .ready(ready0), .busy(busy0), .done(done0), .product(product0)
  );

  mul8x8_seq #(.EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .product(product1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop and compare on every done pulse; an unexpected done is an error.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done0) begin
      if (q0.size() == 0) chk("spurious_done0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("product0", {16'h0, product0}, {16'h0, e.prod});
        chk("latency0", cyc, e.due);
      end
    end
    if (rst_n && done1) begin
      if (q1.size() == 0) chk("spurious_done1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("product1", {16'h0, product1}, {16'h0, e.prod});
        chk("latency1", cyc, e.due);
      end
    end
  end

  task automatic issue(input bit sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] prod, input int lat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!(sel ? ready1 : ready0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("ready_timeout", 32'd0, 32'd1);
    if (sel) begin a1 = a; b1 = b; start1 = 1'b1; end
    else     begin a0 = a; b0 = b; start0 = 1'b1; end
    @(posedge clk);
    #1;
    e.prod = prod;
    e.due  = cyc + lat;
    if (sel) begin q1.push_back(e); start1 = 1'b0; end
    else     begin q0.push_back(e); start0 = 1'b0; end
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while (((sel ? q1.size() : q0.size()) != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("ready_after", {31'd0, sel ? ready1 : ready0}, 32'd1);
  endtask

  initial begin
    exp_t e;
    int   n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_product", {16'h0, product0}, 32'h0);
    rst_n = 1'b1;

    // EARLY_EXIT=0, fixed 8-cycle latency
    issue(1'b0, 8'h0F, 8'h0F, 16'h00E1, 8);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("busy_run", {31'd0, busy0}, 32'd1);
      chk("ready_run", {31'd0, ready0}, 32'd0);
    end
    wait_idle(1'b0);
    issue(1'b0, 8'hFF, 8'hFF, 16'hFE01, 8);
    wait_idle(1'b0);
    issue(1'b0, 8'h00, 8'hAB, 16'h0000, 8);
    wait_idle(1'b0);

    // start held and operands toggled during RUN
    @(negedge clk);
    a0 = 8'h12; b0 = 8'h34; start0 = 1'b1;
    @(posedge clk);
    #1;
    e.prod = 16'h03A8; e.due = cyc + 8; q0.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a0 = ~a0; b0 = b0 + 8'h11;
      chk("busy_hold", {31'd0, busy0}, 32'd1);
    end
    start0 = 1'b0;
    wait_idle(1'b0);

    // Back-to-back: start in the done cycle
    issue(1'b0, 8'h05, 8'h07, 16'h0023, 8);
    n = 0;
    @(negedge clk);
    while (!done0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("b2b_done_timeout", 32'd0, 32'd1);
    chk("b2b_ready_in_done", {31'd0, ready0}, 32'd1);
    a0 = 8'h10; b0 = 8'h10; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    e.prod = 16'h0100; e.due = cyc + 8; q0.push_back(e);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("b2b_hold", {16'h0, product0}, 32'h0023);
    end
    wait_idle(1'b0);

    // Reset during RUN discards the operation
    @(negedge clk);
    a0 = 8'h33; b0 = 8'h33; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'd0, ready0}, 32'd1);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    chk("midrst_done", {31'd0, done0}, 32'd0);
    chk("midrst_product", {16'h0, product0}, 32'h0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // EARLY_EXIT=1
    issue(1'b1, 8'h80, 8'h03, 16'h0180, 2);
    wait_idle(1'b1);
    issue(1'b1, 8'h5A, 8'h00, 16'h0000, 1);
    wait_idle(1'b1);
    issue(1'b1, 8'h02, 8'h80, 16'h0100, 8);
    wait_idle(1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mul8x8_seq.md
Name: mul8x8_seq

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier for the 8x8mul design.
- Registers the operands, accumulates one partial product per clock through a 16-bit combinational adder, and presents a registered 16-bit product with a start/done handshake.
- Sits upstream of the product consumer and directly drives the accumulate adder, which is an instantiated sub-block.

Parameters:
- EARLY_EXIT, 0, when 1 the block finishes as soon as the remaining multiplier bits are all zero; when 0 latency is always 8 cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only while ready=1.
- a  input  8  multiplicand, unsigned; sampled on the accepting edge.
- b  input  8  multiplier, unsigned; sampled on the accepting edge.
- ready  output  1  high in IDLE; start is accepted when start=1 and ready=1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when product updates.
- product  output  16  registered result; holds until the next completion.

Behaviour:
- Reset (rst_n=0 at a rising edge, valid in any state including mid-RUN):
  - state=IDLE; ready=1, busy=0, done=0, product=0x0000.
  - Internal mcand, mplier, acc and cnt cleared.
  - An in-flight operation is discarded; no done pulse is produced for it.
- States: IDLE, RUN.
- IDLE:
  - On start=1, load mcand={8'h00,a}, mplier=b, acc=0, cnt=0, and go to RUN.
  - ready=1 and busy=0 while in IDLE.
- RUN, each edge:
  - sum = acc + (mplier[0] ? mcand : 0), computed by the adder sub-block, modulo 2^16 (no overflow is possible for 8x8).
  - acc<=sum; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
- Finish condition in RUN: cnt==7, or (EARLY_EXIT==1 and (mplier>>1)==0).
  - On finish: product<=sum, done<=1 for exactly one cycle, state<=IDLE.
- Latency:
  - EARLY_EXIT=0: done is asserted 8 clocks after the accepting edge.
  - EARLY_EXIT=1: done is asserted at 1 + index of the MSB set in b clocks; b=0 gives 1 clock.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt the operands.
- Back-to-back operation: ready is high in the cycle done is high, so a start in that cycle is accepted. The new operation begins RUN on the next edge and product keeps the previous result until the new completion.
- a and b may change freely after acceptance.
- done and product are registered outputs with no combinational path from the inputs. ready and busy decode state.
- cnt is 3 bits and does not wrap in use; the finish condition is checked at cnt==7.

Decomposition:
- Shared package mul8x8_pkg holds:
  - state enum {IDLE, RUN}.
  - constants OP_W=8, PROD_W=16, CNT_W=3, LAST_CNT=3'd7.
- One sub-module: the existing 16-bit combinational adder adder16 (out, in1, in2).
  - Instantiated once, with in1=acc and in2=gated mcand.
  - No other adder is inferred in this block.
- FSM, shift registers and counter stay in the top module.

Test Plan:
- EARLY_EXIT=0, a=0x0F, b=0x0F, start pulse -> busy for 8 cycles; done pulses 8 clocks after acceptance; product=0x00E1; ready returns to 1.
- a=0xFF, b=0xFF -> product=0xFE01 after 8 clocks. a=0x00, b=0xAB -> product=0x0000 with done still at 8 clocks.
- Start 0x12*0x34 -> 0x03A8, with start held high and a/b toggled during RUN -> exactly one done, result 0x03A8, no restart until ready.
- Back-to-back: 0x05*0x07, then start asserted in the done cycle with 0x10*0x10.
  - product=0x0023, then 0x0100 eight clocks later.
  - product holds 0x0023 in between.
- Reset mid-op: assert rst_n=0 at cycle 4 of RUN -> next edge gives ready=1, busy=0, done=0, product=0x0000, and no later done pulse.
- EARLY_EXIT=1:
  - b=0x03, a=0x80 -> done after 2 clocks, product=0x0180.
  - b=0x00 -> done after 1 clock, product=0x0000.
  - b=0x80, a=0x02 -> done after 8 clocks, product=0x0100.
